// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_arbiter                                                   |
// | Brief  : Shares one UART transmitter between two registered-read TX FIFOs. |
// |          Bytes are popped one at a time from the granted channel, loaded   |
// |          into tx_data and launched with a one-cycle tx_start. After each   |
// |          tx_done_tick the next grant is decided round-robin, with at most  |
// |          BURST_MAX consecutive bytes per grant while the other channel     |
// |          has data.                                                         |
// | Ports  : clk          - system clock, rising edge                           |
// |          reset        - asynchronous reset, active low                      |
// |          empty0/1     - FIFO empty flags                                    |
// |          rd0/1        - FIFO read strobes (one cycle, never both high)      |
// |          r_data0/1    - FIFO read data, valid the cycle after rd            |
// |          tx_start     - one-cycle start pulse to the transmitter            |
// |          tx_data      - byte to transmit, held from START to next LOAD      |
// |          tx_done_tick - end-of-frame pulse from the transmitter             |
// |          sel          - channel currently or last granted                   |
// |          busy         - high whenever the arbiter is not idle               |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty0,
  output logic                  rd0,
  input  logic [DATA_WIDTH-1:0] r_data0,
  input  logic                  empty1,
  output logic                  rd1,
  input  logic [DATA_WIDTH-1:0] r_data1,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done_tick,
  output logic                  sel,
  output logic                  busy
);

  localparam logic [3:0] C_BURST_LIM = 4'(BURST_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  state_e                state_q;
  logic                  sel_q;
  logic                  rr_ptr_q;
  logic [3:0]            burst_cnt_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  rd0_q;
  logic                  rd1_q;
  logic                  tx_start_q;
  logic                  busy_q;

  // Channel chosen from IDLE: the only non-empty one, or rr_ptr when both wait.
  logic w_idle_pick;
  // Empty flags seen from the point of view of the current grant.
  logic w_cur_empty;
  logic w_oth_empty;
  // The current channel may keep the grant for one more byte.
  logic w_stay;

  assign w_idle_pick = (!empty0 && !empty1) ? rr_ptr_q : empty0;
  assign w_cur_empty = sel_q ? empty1 : empty0;
  assign w_oth_empty = sel_q ? empty0 : empty1;
  assign w_stay      = !w_cur_empty && ((burst_cnt_q < C_BURST_LIM) || w_oth_empty);

  // Outputs are registered alongside the state so rd/tx_start are high exactly
  // while the FSM sits in POP/START, and busy exactly while it is not in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= 4'd0;
      tx_data_q   <= '0;
      rd0_q       <= 1'b0;
      rd1_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!empty0 || !empty1) begin
            sel_q       <= w_idle_pick;
            burst_cnt_q <= 4'd0;
            rd0_q       <= !w_idle_pick;
            rd1_q       <= w_idle_pick;
            busy_q      <= 1'b1;
            state_q     <= ST_POP;
          end
        end
        ST_POP: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_q  <= sel_q ? r_data1 : r_data0;
          tx_start_q <= 1'b1;
          state_q    <= ST_START;
        end
        ST_START: begin
          // Saturate so a long single-channel run never wraps back under the limit.
          if (burst_cnt_q < C_BURST_LIM) begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
          end
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (w_stay) begin
              rd0_q   <= !sel_q;
              rd1_q   <= sel_q;
              state_q <= ST_POP;
            end else if (!w_oth_empty) begin
              sel_q       <= !sel_q;
              burst_cnt_q <= 4'd0;
              rr_ptr_q    <= sel_q;
              rd0_q       <= sel_q;
              rd1_q       <= !sel_q;
              state_q     <= ST_POP;
            end else begin
              // Next contention from IDLE favours the channel just left waiting.
              rr_ptr_q <= !sel_q;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd0      = rd0_q;
  assign rd1      = rd1_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sel      = sel_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_arbiter                                                |
// | Brief  : Self-checking bench for uart_tx_arbiter. Two behavioural FIFOs,   |
// |          a transmitter model with random frame length and a transaction-   |
// |          level grant model predict every pop, byte, channel and latency.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int BM = 4;

  logic          clk;
  logic          reset;
  logic          empty0, empty1;
  logic          rd0, rd1;
  logic [DW-1:0] r_data0, r_data1;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_done_tick;
  logic          sel;
  logic          busy;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk          (clk),
    .reset        (reset),
    .empty0       (empty0),
    .rd0          (rd0),
    .r_data0      (r_data0),
    .empty1       (empty1),
    .rd1          (rd1),
    .r_data1      (r_data1),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .sel          (sel),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents, pending writes and transmit log
  logic [7:0] fq0[$], fq1[$], pend0[$], pend1[$], log_b[$];
  logic       log_s[$];

  int n_total, n_bad, cyc, n_rst;

  // Grant model state
  bit         m_busy, m_rr, m_cur;
  int         m_burst;
  bit         exp_valid, exp_ch;
  logic [7:0] exp_byte;
  int         exp_dcyc;

  // Transmitter model / random traffic
  bit tx_busy;
  int tx_cnt;
  bit rand_on;
  int wr_pct;

  logic [7:0] rr_exp [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                              8'h04, 8'h05, 8'h06, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit q_empty(input bit ch);
    return ch ? (fq1.size() == 0) : (fq0.size() == 0);
  endfunction

  task automatic grant(input bit ch);
    exp_valid = 1'b1;
    exp_ch    = ch;
    exp_byte  = ch ? fq1[0] : fq0[0];
    exp_dcyc  = cyc;
  endtask

  task automatic decide_idle();
    bit ch;
    ch = (!q_empty(0) && !q_empty(1)) ? m_rr : q_empty(0);
    m_cur   = ch;
    m_burst = 1;
    m_busy  = 1'b1;
    grant(ch);
  endtask

  task automatic decide_done();
    bit other;
    other = !m_cur;
    if (!q_empty(m_cur) && (m_burst < BM || q_empty(other))) begin
      if (m_burst < BM) m_burst++;
      grant(m_cur);
    end else if (!q_empty(other)) begin
      m_rr    = m_cur;
      m_cur   = other;
      m_burst = 1;
      grant(other);
    end else begin
      m_rr   = !m_cur;
      m_busy = 1'b0;
    end
  endtask

  // One cycle of bench activity, called just after each falling edge.
  task automatic step();
    bit done_now;
    cyc++;
    check_val("rd_excl", rd0 & rd1, 0);
    check_val("busy", busy, m_busy);
    if (rd0 | rd1) begin
      check_val("rd_exp", exp_valid, 1);
      check_val("rd_ch", rd1, exp_ch);
      check_val("rd_lat", cyc, exp_dcyc + 1);
      if (rd1) begin
        check_val("rd_nonempty1", fq1.size() > 0, 1);
        if (fq1.size() > 0) r_data1 = fq1.pop_front();
      end else begin
        check_val("rd_nonempty0", fq0.size() > 0, 1);
        if (fq0.size() > 0) r_data0 = fq0.pop_front();
      end
    end
    done_now     = 1'b0;
    tx_done_tick = 1'b0;
    if (tx_start) begin
      check_val("start_dup", tx_busy, 0);
      check_val("start_exp", exp_valid, 1);
      check_val("tx_data", tx_data, exp_byte);
      check_val("sel", sel, exp_ch);
      check_val("start_lat", cyc, exp_dcyc + 3);
      log_b.push_back(tx_data);
      log_s.push_back(sel);
      exp_valid = 1'b0;
      tx_busy   = 1'b1;
      tx_cnt    = int'($urandom_range(6, 1));
    end else if (tx_busy) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done_tick = 1'b1;
        tx_busy      = 1'b0;
        done_now     = 1'b1;
      end
    end else if (rand_on && $urandom_range(99) < 5) begin
      // stray tick while nothing is in flight; must be ignored
      tx_done_tick = 1'b1;
    end
    while (pend0.size() > 0) fq0.push_back(pend0.pop_front());
    while (pend1.size() > 0) fq1.push_back(pend1.pop_front());
    if (rand_on) begin
      if ($urandom_range(99) < wr_pct) fq0.push_back(8'($urandom));
      if ($urandom_range(99) < wr_pct) fq1.push_back(8'($urandom));
    end
    if (done_now) decide_done();
    else if (!m_busy && (!q_empty(0) || !q_empty(1))) decide_idle();
    empty0 = (fq0.size() == 0);
    empty1 = (fq1.size() == 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    check_val("rst_rd0", rd0, 0);
    check_val("rst_rd1", rd1, 0);
    check_val("rst_start", tx_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_sel", sel, 0);
    check_val("rst_data", tx_data, 0);
    repeat (n) @(negedge clk);
    m_busy = 1'b0; m_rr = 1'b0; m_cur = 1'b0; m_burst = 0;
    exp_valid = 1'b0; tx_busy = 1'b0; tx_cnt = 0; tx_done_tick = 1'b0;
    reset = 1'b1;
    n_rst++;
    step();
  endtask

  task automatic run_quiet(input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      step();
      k++;
    end while (!(!m_busy && !tx_busy && !exp_valid && fq0.size() == 0 && fq1.size() == 0 &&
                 pend0.size() == 0 && pend1.size() == 0) && k < max);
    check_val("quiet_timeout", k < max, 1);
    @(negedge clk);
    step();
  endtask

  initial begin
    bit want_rst;
    reset = 1'b1; empty0 = 1'b1; empty1 = 1'b1;
    r_data0 = '0; r_data1 = '0; tx_done_tick = 1'b0;
    rand_on = 1'b0; wr_pct = 6;
    n_total = 0; n_bad = 0; cyc = 0; n_rst = 0;
    m_busy = 0; m_rr = 0; m_cur = 0; m_burst = 0; exp_valid = 0; tx_busy = 0; tx_cnt = 0;

    @(negedge clk);
    do_reset(2);

    // Round-robin with bursts from a fresh reset (channel 0 preferred)
    for (int i = 0; i < 8; i++) begin
      pend0.push_back(8'(i));
      pend1.push_back(8'(8'h10 + i));
    end
    log_b.delete(); log_s.delete();
    run_quiet(2000);
    check_val("rr_count", log_b.size(), 16);
    for (int i = 0; i < 16 && i < log_b.size(); i++) check_val("rr_order", log_b[i], rr_exp[i]);

    // Single channel, two bytes
    pend0.push_back(8'hA5); pend0.push_back(8'h3C);
    log_b.delete(); log_s.delete();
    run_quiet(500);
    check_val("single_count", log_b.size(), 2);
    if (log_b.size() == 2) begin
      check_val("single_b0", log_b[0], 8'hA5);
      check_val("single_b1", log_b[1], 8'h3C);
    end

    // Fairness from IDLE: last service ended on channel 0
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(8'(8'h40 + i));
      pend1.push_back(8'(8'h50 + i));
    end
    log_b.delete(); log_s.delete();
    run_quiet(1000);
    check_val("fair_count", log_s.size(), 6);
    if (log_s.size() > 0) check_val("fair_first_sel", log_s[0], 1);

    // Burst overrun with the other channel empty
    for (int i = 0; i < 6; i++) pend0.push_back(8'(8'h60 + i));
    log_b.delete(); log_s.delete();
    run_quiet(1000);
    check_val("overrun_count", log_b.size(), 6);
    for (int i = 0; i < 6 && i < log_b.size(); i++) check_val("overrun_byte", log_b[i], 8'(8'h60 + i));

    // Random traffic with resets injected while a frame is in flight
    rand_on = 1'b1;
    want_rst = 1'b0;
    n_rst = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      step();
      if (k == 1000 || k == 2500) want_rst = 1'b1;
      if (want_rst && tx_busy && tx_cnt >= 2 && !tx_start) begin
        want_rst = 1'b0;
        do_reset(2);
      end
    end
    rand_on = 1'b0;
    run_quiet(20000);
    check_val("rst_injected", n_rst, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
